// File: rtl/spi_slave_rx.sv
// SPI mode-0 receive-only slave: synchronizes SCLK/CS_N/MOSI into m_clk, rebuilds words, queues them in a FWFT FIFO.
// Optional macro SPI_RX_LSB_FIRST_EN selects LSB-first bit order (default MSB first).
module spi_slave_rx #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              m_clk,
  input  logic              reset,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic              ovr_clr,
  output logic              overrun,
  output logic              frame_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {WAIT_HI, IDLE, SHIFT} state_t;

  // Synchronizers and edge-detect history
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_hist;
  logic                   r_cs_hist;

  logic w_sclk;
  logic w_cs_n;
  logic w_mosi;
  logic w_sclk_rise;
  logic w_cs_fall;
  logic w_cs_rise;

  // CS synchronizer resets low so a frame held open across reset never looks like an idle-to-active edge.
  always_ff @(posedge m_clk) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '0;
      r_mosi_sync <= '0;
      r_sclk_hist <= 1'b0;
      r_cs_hist   <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_sclk_hist <= w_sclk;
      r_cs_hist   <= w_cs_n;
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_n      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_hist;
  assign w_cs_fall   = ~w_cs_n & r_cs_hist;
  assign w_cs_rise   = w_cs_n & ~r_cs_hist;

  // Frame FSM and shift register
  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [DATA_W-1:0] r_sh;
  logic [DATA_W-1:0] w_sh_nxt;
  logic [DATA_W-1:0] w_sh_shift;
  logic              r_push;
  logic              w_push_nxt;
  logic              r_frame_err;
  logic              w_fe_nxt;

`ifdef SPI_RX_LSB_FIRST_EN
  assign w_sh_shift = {w_mosi, r_sh[DATA_W-1:1]};
`else
  assign w_sh_shift = {r_sh[DATA_W-2:0], w_mosi};
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sh_nxt    = r_sh;
    w_push_nxt  = 1'b0;
    w_fe_nxt    = 1'b0;
    case (r_state)
      WAIT_HI: begin
        if (w_cs_n) w_state_nxt = IDLE;
      end
      IDLE: begin
        if (w_cs_fall) begin
          w_cnt_nxt   = '0;
          w_sh_nxt    = '0;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        // A CS rise masks a coincident SCLK rise.
        if (w_cs_rise) begin
          w_fe_nxt    = (r_cnt != '0);
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else if (w_sclk_rise) begin
          w_sh_nxt = w_sh_shift;
          if (r_cnt == CW'(DATA_W - 1)) begin
            w_cnt_nxt  = '0;
            w_push_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = WAIT_HI;
    endcase
  end

  always_ff @(posedge m_clk) begin
    if (reset) begin
      r_state     <= WAIT_HI;
      r_cnt       <= '0;
      r_sh        <= '0;
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sh        <= w_sh_nxt;
      r_push      <= w_push_nxt;
      r_frame_err <= w_fe_nxt;
    end
  end

  // Receive FIFO, first-word-fall-through
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  logic              r_overrun;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_wr;
  logic              w_ovr_set;

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop     = ~w_empty & rx_ready;
  // r_sh still holds the completed word during the push cycle; the next shift is several cycles away.
  assign w_wr      = r_push & (~w_full | w_pop);
  assign w_ovr_set = r_push & w_full & ~w_pop;

  always_ff @(posedge m_clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr[AW-1:0]] <= r_sh;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_ovr_set)    r_overrun <= 1'b1;
      else if (ovr_clr) r_overrun <= 1'b0;
    end
  end

  assign rx_data   = r_mem[r_rptr[AW-1:0]];
  assign rx_valid  = ~w_empty;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Scoreboard bench for spi_slave_rx: stimulus pushes expected words, a negedge monitor pops and compares on every DUT pop.
module tb_spi_slave_rx;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          m_clk = 1'b0;
  logic          reset = 1'b1;
  logic          spi_sclk = 1'b0;
  logic          spi_cs_n = 1'b1;
  logic          spi_mosi = 1'b0;
  logic          rx_ready = 1'b0;
  logic          ovr_clr = 1'b0;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          overrun;
  logic          frame_err;

  spi_slave_rx #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .m_clk(m_clk), .reset(reset), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .ovr_clr(ovr_clr), .overrun(overrun), .frame_err(frame_err)
  );

  always #5 m_clk = ~m_clk;

  int            n_checks = 0;
  int            n_pass = 0;
  logic [DW-1:0] exp_q[$];
  bit            exp_ovr = 0;
  int            exp_fe = 0;
  int            fe_count = 0;
  bit            fe_prev = 0;
  bit            fe_long = 0;
  bit            rdy_rand = 0;
  bit            rdy_force = 0;
  bit            rdy_manual = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  // Receiver bit order decides how a transmitted byte lands in rx_data.
  function automatic logic [DW-1:0] model_word(input logic [DW-1:0] w);
`ifdef SPI_RX_LSB_FIRST_EN
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = w[DW-1-i];
    return r;
`else
    return w;
`endif
  endfunction

  // Monitor: every DUT pop is compared against the scoreboard head.
  always @(negedge m_clk) begin
    if (frame_err) begin
      if (fe_prev) fe_long = 1;
      fe_count++;
    end
    fe_prev = frame_err;
    if (!reset && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) check("pop_with_empty_model", rx_valid, 1'b0);
      else check("rx_data", rx_data, exp_q.pop_front());
    end
  end

  always @(posedge m_clk) begin
    #1;
    if (!rdy_manual) rx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge m_clk);
    #1;
  endtask

  // Sends the top nbits of w MSB first at sclk = m_clk/8.
  task automatic send_word(input logic [DW-1:0] w, input int nbits, input bit model_en, input bit pop_at_push);
    for (int i = DW - 1; i >= DW - nbits; i--) begin
      spi_mosi = w[i];
      tick(4);
      spi_sclk = 1'b1;
      if (i == 0 && model_en) begin
        if (pop_at_push || exp_q.size() < DEPTH) exp_q.push_back(model_word(w));
        else exp_ovr = 1;
      end
      if (i == 0 && pop_at_push) begin
        // 2 sync flops + edge detect + push register: FIFO write lands on the 4th edge.
        tick(3);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
      end else begin
        tick(4);
      end
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_open();
    spi_cs_n = 1'b0;
    tick(6);
  endtask

  task automatic cs_close();
    tick(4);
    spi_cs_n = 1'b1;
    tick(8);
  endtask

  task automatic wait_below(input int lim);
    int t = 0;
    while (exp_q.size() >= lim && t < 600) begin
      tick(1);
      t++;
    end
    if (exp_q.size() >= lim) check("drain_timeout", exp_q.size(), lim - 1);
  endtask

  task automatic drain();
    rdy_force = 1;
    wait_below(1);
    tick(4);
    check("empty_after_drain", rx_valid, 1'b0);
  endtask

  initial begin
    int nw;
    tick(4);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_rx_data", rx_data, '0);
    check("reset_overrun", overrun, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    reset = 1'b0;
    tick(6);
    check("post_reset_rx_valid", rx_valid, 1'b0);

    // Single word
    rdy_force = 0;
    cs_open();
    send_word(8'hA5, DW, 1, 0);
    cs_close();
    check("a5_valid", rx_valid, 1'b1);
    check("a5_data", rx_data, model_word(8'hA5));
    drain();

    // Three words in one frame, queued
    rdy_force = 0;
    cs_open();
    send_word(8'h02, DW, 1, 0);
    send_word(8'h03, DW, 1, 0);
    send_word(8'h04, DW, 1, 0);
    cs_close();
    check("three_valid", rx_valid, 1'b1);
    drain();

    // Overflow
    rdy_force = 0;
    cs_open();
    for (int i = 0; i < 4; i++) send_word(8'h10 + 8'(i), DW, 1, 0);
    tick(8);
    check("ovr_after_4", overrun, exp_ovr);
    send_word(8'h14, DW, 1, 0);
    tick(8);
    check("ovr_after_5", overrun, exp_ovr);
    send_word(8'h15, DW, 1, 0);
    cs_close();
    check("ovr_sticky", overrun, exp_ovr);
    ovr_clr = 1'b1;
    tick(1);
    ovr_clr = 1'b0;
    exp_ovr = 0;
    check("ovr_cleared", overrun, exp_ovr);
    drain();

    // Full FIFO with a pop in the push cycle
    rdy_force = 0;
    cs_open();
    for (int i = 0; i < 4; i++) send_word(8'h20 + 8'(i), DW, 1, 0);
    tick(4);
    rdy_manual = 1;
    rx_ready = 1'b0;
    send_word(8'h99, DW, 1, 1);
    rdy_manual = 0;
    tick(8);
    check("full_pop_no_ovr", overrun, exp_ovr);
    cs_close();
    drain();

    // Partial word then a clean frame
    rdy_force = 1;
    cs_open();
    send_word(8'hFF, 5, 0, 0);
    cs_close();
    exp_fe++;
    check("frame_err_count", fe_count, exp_fe);
    cs_open();
    send_word(8'h3C, DW, 1, 0);
    cs_close();
    drain();

    // Reset mid-word with CS held low
    rdy_force = 1;
    cs_open();
    send_word(8'hE0, 3, 0, 0);
    reset = 1'b1;
    tick(2);
    check("midreset_valid", rx_valid, 1'b0);
    check("midreset_frame_err", frame_err, 1'b0);
    reset = 1'b0;
    tick(4);
    send_word(8'h77, DW, 0, 0);
    tick(8);
    check("no_word_while_wait_hi", rx_valid, 1'b0);
    cs_close();
    cs_open();
    send_word(8'h5A, DW, 1, 0);
    cs_close();
    drain();

    // LSB-first byte order probe (0x01 -> 0x80 when enabled)
    rdy_force = 0;
    cs_open();
    send_word(8'h01, DW, 1, 0);
    cs_close();
`ifdef SPI_RX_LSB_FIRST_EN
    check("lsb_first_01", rx_data, 8'h80);
`else
    check("msb_first_01", rx_data, 8'h01);
`endif
    drain();

    // Randomized frames with random pop pressure
    rdy_rand = 1;
    for (int f = 0; f < 8; f++) begin
      nw = $urandom_range(1, 3);
      cs_open();
      for (int k = 0; k < nw; k++) begin
        wait_below(DEPTH);
        send_word(8'($urandom), DW, 1, 0);
      end
      cs_close();
    end
    rdy_rand = 0;
    drain();

    check("final_frame_err_count", fe_count, exp_fe);
    check("frame_err_one_cycle", fe_long, 1'b0);
    check("final_overrun", overrun, exp_ovr);
    check("final_model_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
